// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz VGA timing constants.
// Imported by the timing generator and by the downstream pattern generator,
// which takes its row/column widths from COL_W/ROW_W.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync windows, both ends inclusive.
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int unsigned COL_W = 10;
  localparam int unsigned ROW_W = 9;

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// mod_counter: modulus-N up counter with enable.
// Ports:
//   clk_i   system clock
//   rst_ni  synchronous active-low reset (to 0)
//   en_i    count enable
//   cnt_o   current count, 0..N-1
//   wrap_o  high while the count sits at N-1 (the next enabled edge wraps)
module mod_counter #(
  parameter int unsigned N = 800,
  parameter int unsigned W = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_d, cnt_q;

  // Carry is a pure decode of the count so a cascaded stage can qualify it
  // with its own enable.
  assign wrap_o = (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// Two cascaded mod_counters hold the next position to present; every output
// is a register loaded from the decode of that position on enabled edges, so
// all outputs describe the same pixel and none depends combinationally on
// an input.
// Ports:
//   clk_i          system clock
//   rst_ni         synchronous active-low reset
//   en_i           pixel tick
//   column_o       pixel column, 0 outside the visible area
//   row_o          line index, 0 outside the visible area
//   active_o       visible-area flag
//   hsync_o        horizontal sync, active-low
//   vsync_o        vertical sync, active-low
//   frame_start_o  one-clk strobe when (0,0) is presented
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [COL_W-1:0] column_o,
  output logic [ROW_W-1:0] row_o,
  output logic             active_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             frame_start_o
);

  localparam int unsigned CNT_W = 10;
  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST_C  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_FIRST_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST_C  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap;
  logic             v_wrap_unused;

  mod_counter #(.N(H_TOT), .W(CNT_W)) u_h_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_i),
    .cnt_o  (h_cnt),
    .wrap_o (h_wrap)
  );

  mod_counter #(.N(V_TOT), .W(CNT_W)) u_v_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_i & h_wrap),
    .cnt_o  (v_cnt),
    .wrap_o (v_wrap_unused)
  );

  logic active_dec, hsync_dec, vsync_dec;

  always_comb begin
    active_dec = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hsync_dec  = !((h_cnt >= HS_FIRST_C) && (h_cnt <= HS_LAST_C));
    // vsync spans whole lines, so it ignores h entirely.
    vsync_dec  = !((v_cnt >= VS_FIRST_C) && (v_cnt <= VS_LAST_C));
  end

  logic [COL_W-1:0] column_d, column_q;
  logic [ROW_W-1:0] row_d, row_q;
  logic             active_d, active_q;
  logic             hsync_d, hsync_q;
  logic             vsync_d, vsync_q;
  logic             frame_start_d, frame_start_q;

  always_comb begin
    column_d      = column_q;
    row_d         = row_q;
    active_d      = active_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    // Strobe self-clears on any edge, enabled or not.
    frame_start_d = 1'b0;
    if (en_i) begin
      // Clamp position to zero in blanking instead of exposing raw counts.
      column_d      = active_dec ? h_cnt[COL_W-1:0] : '0;
      row_d         = active_dec ? v_cnt[ROW_W-1:0] : '0;
      active_d      = active_dec;
      hsync_d       = hsync_dec;
      vsync_d       = vsync_dec;
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      column_q      <= '0;
      row_q         <= '0;
      active_q      <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      column_q      <= column_d;
      row_q         <= row_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign column_o      = column_q;
  assign row_o         = row_q;
  assign active_o      = active_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Instance 0 uses the real 640x480 timing; instance 1
// uses a shrunken raster (25 x 19) so vertical sync and frame wrap are reachable
// in a short run. Both share clock, reset and enable and are compared against a
// position-walking reference model every cycle.
module tb_vga_timing_gen;

  logic clk;
  logic rst_ni;
  logic en_i;

  logic [9:0] col_a, col_b;
  logic [8:0] row_a, row_b;
  logic       act_a, act_b, hs_a, hs_b, vs_a, vs_b, fs_a, fs_b;

  vga_timing_gen u_dut_full (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .en_i          (en_i),
    .column_o      (col_a),
    .row_o         (row_a),
    .active_o      (act_a),
    .hsync_o       (hs_a),
    .vsync_o       (vs_a),
    .frame_start_o (fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_dut_small (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .en_i          (en_i),
    .column_o      (col_b),
    .row_o         (row_b),
    .active_o      (act_b),
    .hsync_o       (hs_b),
    .vsync_o       (vs_b),
    .frame_start_o (fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference raster descriptions for both instances.
  int c_ha [2] = '{640, 16};
  int c_hf [2] = '{16, 2};
  int c_hs [2] = '{96, 4};
  int c_hb [2] = '{48, 3};
  int c_va [2] = '{480, 12};
  int c_vf [2] = '{10, 2};
  int c_vs [2] = '{2, 2};
  int c_vb [2] = '{33, 3};

  int mh [2];          // next position to be presented
  int mv [2];
  int ph [2];          // position presented by the most recent enabled edge
  int pv [2];
  logic [22:0] exp_v [2];
  logic [22:0] obs [2];

  localparam logic [22:0] RESET_VEC = {10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0};

  always_comb begin
    obs[0] = {col_a, row_a, act_a, hs_a, vs_a, fs_a};
    obs[1] = {col_b, row_b, act_b, hs_b, vs_b, fs_b};
  end

  function automatic logic [22:0] raster_at(int k, int h, int v, logic fs);
    logic       act, hs, vs;
    logic [9:0] c;
    logic [8:0] r;
    act = (h < c_ha[k]) && (v < c_va[k]);
    hs  = !((h >= c_ha[k] + c_hf[k]) && (h < c_ha[k] + c_hf[k] + c_hs[k]));
    vs  = !((v >= c_va[k] + c_vf[k]) && (v < c_va[k] + c_vf[k] + c_vs[k]));
    c   = act ? 10'(h) : 10'd0;
    r   = act ? 9'(v) : 9'd0;
    return {c, r, act, hs, vs, fs};
  endfunction

  // Apply one clock with the given inputs and advance the model the same way.
  task automatic step(input logic en, input logic rst);
    int htot, vtot;
    en_i   = en;
    rst_ni = rst;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      htot = c_ha[k] + c_hf[k] + c_hs[k] + c_hb[k];
      vtot = c_va[k] + c_vf[k] + c_vs[k] + c_vb[k];
      if (!rst) begin
        mh[k] = 0;
        mv[k] = 0;
        exp_v[k] = RESET_VEC;
      end else if (en) begin
        exp_v[k] = raster_at(k, mh[k], mv[k], (mh[k] == 0) && (mv[k] == 0));
        ph[k] = mh[k];
        pv[k] = mv[k];
        mh[k]++;
        if (mh[k] == htot) begin
          mh[k] = 0;
          mv[k]++;
          if (mv[k] == vtot) mv[k] = 0;
        end
      end else begin
        exp_v[k][0] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs[k] !== RESET_VEC) begin
          n_err++;
          $display("FAIL reset inst%0d cyc%0d: got %h, want %h", k, i, obs[k], RESET_VEC);
        end
      end
    end
    step(1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs[k] !== exp_v[k] || obs[k][0] !== 1'b1 || obs[k][3] !== 1'b1) begin
        n_err++;
        $display("FAIL first_edge inst%0d: got %h, want %h", k, obs[k], exp_v[k]);
      end
    end
    step(1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs[k] !== exp_v[k] || obs[k][0] !== 1'b0) begin
        n_err++;
        $display("FAIL fs_one_clk inst%0d: got %h, want %h", k, obs[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_hsync_line();
    logic hs_prev, act_prev;
    int fall_h = -1, fall_t = -1, fall2_t = -1, rise_h = -1, rise_t = -1, actf_h = -1;
    hs_prev  = hs_a;
    act_prev = act_a;
    for (int n = 0; n < 1700; n++) begin
      step(1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs[k] !== exp_v[k]) begin
          n_err++;
          $display("FAIL line inst%0d (%0d,%0d): got %h, want %h", k, ph[k], pv[k], obs[k], exp_v[k]);
        end
      end
      if (hs_prev && !hs_a) begin
        if (fall_t < 0) begin fall_h = ph[0]; fall_t = n; end
        else if (fall2_t < 0) fall2_t = n;
      end
      if (!hs_prev && hs_a && fall_t >= 0 && rise_t < 0) begin rise_h = ph[0]; rise_t = n; end
      if (act_prev && !act_a && actf_h < 0) actf_h = ph[0];
      hs_prev  = hs_a;
      act_prev = act_a;
    end
    n_vec++;
    if (fall_h != 656) begin
      n_err++;
      $display("FAIL hsync_fall_col: got %0d, want 656", fall_h);
    end
    n_vec++;
    if (rise_h != 752 || rise_t - fall_t != 96) begin
      n_err++;
      $display("FAIL hsync_rise: col %0d width %0d, want col 752 width 96", rise_h, rise_t - fall_t);
    end
    n_vec++;
    if (fall2_t - fall_t != 800) begin
      n_err++;
      $display("FAIL line_period: got %0d, want 800", fall2_t - fall_t);
    end
    n_vec++;
    if (actf_h != 640) begin
      n_err++;
      $display("FAIL active_fall_col: got %0d, want 640", actf_h);
    end
  endtask

  task automatic test_stall();
    logic en;
    logic fs_prev_b;
    fs_prev_b = fs_b;
    for (int n = 0; n < 1514; n++) begin
      if (n < 4)       en = (n % 2 == 0);
      else if (n < 14) en = 1'b0;
      else             en = ($urandom_range(0, 2) != 0);
      step(en, 1'b1);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs[k] !== exp_v[k]) begin
          n_err++;
          $display("FAIL stall inst%0d n%0d en%0b: got %h, want %h", k, n, en, obs[k], exp_v[k]);
        end
      end
      n_vec++;
      if ((fs_prev_b && fs_b) || (!act_a && (col_a != 0 || row_a != 0)) ||
          (act_a && (col_a >= 640 || row_a >= 480))) begin
        n_err++;
        $display("FAIL stall_invariants n%0d: fs %0b%0b act %0b col %0d row %0d",
                 n, fs_prev_b, fs_b, act_a, col_a, row_a);
      end
      fs_prev_b = fs_b;
    end
  endtask

  task automatic test_frame();
    int t1 = -1, t2 = -1, vs_low = 0;
    for (int n = 0; n < 1100 && t2 < 0; n++) begin
      step(1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs[k] !== exp_v[k]) begin
          n_err++;
          $display("FAIL frame inst%0d (%0d,%0d): got %h, want %h", k, ph[k], pv[k], obs[k], exp_v[k]);
        end
      end
      if (fs_b) begin
        if (t1 < 0) t1 = n;
        else t2 = n;
      end
      if (t1 >= 0 && t2 < 0 && !vs_b) vs_low++;
    end
    n_vec++;
    if (t1 < 0 || t2 < 0 || t2 - t1 != 475) begin
      n_err++;
      $display("FAIL frame_period: got %0d (t1 %0d t2 %0d), want 475", t2 - t1, t1, t2);
    end
    n_vec++;
    if (vs_low != 50) begin
      n_err++;
      $display("FAIL vsync_width: got %0d, want 50", vs_low);
    end
  endtask

  task automatic test_fs_stall();
    int guard = 0;
    while (!(mh[1] == 0 && mv[1] == 0) && guard < 600) begin
      step(1'b1, 1'b1);
      guard++;
    end
    n_vec++;
    if (guard >= 600) begin
      n_err++;
      $display("FAIL fs_stall_reach: got timeout, want position (0,0)");
    end
    step(1'b1, 1'b1);
    n_vec++;
    if (fs_b !== 1'b1 || obs[1] !== exp_v[1]) begin
      n_err++;
      $display("FAIL fs_stall_set: got %h, want %h", obs[1], exp_v[1]);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs[k] !== exp_v[k] || obs[k][0] !== 1'b0) begin
          n_err++;
          $display("FAIL fs_stall_hold inst%0d: got %h, want %h", k, obs[k], exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (!(mh[1] == 10 && mv[1] == 8) && guard < 600) begin
      step(1'b1, 1'b1);
      guard++;
    end
    n_vec++;
    if (guard >= 600) begin
      n_err++;
      $display("FAIL rst_mid_reach: got timeout, want position (10,8)");
    end
    step(1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs[k] !== RESET_VEC) begin
        n_err++;
        $display("FAIL rst_mid inst%0d: got %h, want %h", k, obs[k], RESET_VEC);
      end
    end
    for (int n = 0; n < 60; n++) begin
      step(1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs[k] !== exp_v[k] || (n == 0 && obs[k][0] !== 1'b1)) begin
          n_err++;
          $display("FAIL rst_restart inst%0d n%0d: got %h, want %h", k, n, obs[k], exp_v[k]);
        end
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    en_i   = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mh[k] = 0; mv[k] = 0; ph[k] = 0; pv[k] = 0;
      exp_v[k] = RESET_VEC;
    end
    #2;
    test_reset();
    test_hsync_line();
    test_stall();
    test_frame();
    test_fs_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480 @ 60 Hz VGA raster timing: horizontal and vertical position counters, active-low sync pulses, an active-video flag and a frame-start strobe. Sits directly upstream of the pattern generator, driving its row_i/column_i inputs. Its hsync_o/vsync_o go to the board VGA connector.

## Interface
Parameters (defaults from the shared package):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels); H_TOTAL = 800
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines); V_TOTAL = 525

Ports:
- clk_i  input  1  system clock; the block has one clock.
- rst_ni  input  1  reset, synchronous, active-low.
- en_i  input  1  pixel tick; position advances only on clk_i edges with en_i=1. Tie high at 25 MHz, or strobe 1-in-2 at 50 MHz.
- column_o  output  10  horizontal pixel index, 0..639 during active video.
- row_o  output  9  vertical line index, 0..479 during active video.
- active_o  output  1  1 when (column, row) is inside the visible area.
- hsync_o  output  1  horizontal sync, active-low.
- vsync_o  output  1  vertical sync, active-low.
- frame_start_o  output  1  one-clk strobe when position (0,0) is presented.

## Operation
- Internal counters h_cnt (10 b, 0..H_TOTAL-1) and v_cnt (10 b, 0..V_TOTAL-1) hold the next position to present.
- On each edge with rst_ni=1 and en_i=1:
  - Outputs are loaded from the decode of (h_cnt, v_cnt).
  - h_cnt increments.
  - At h_cnt=H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt=V_TOTAL-1 together with h_cnt wrap, v_cnt wraps to 0.
- Decode for a position (h, v):
  - active = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vsync low for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491. vsync is asserted over the whole line, independent of h.
  - column_o = h, row_o = v[8:0] when active; both 0 when not active (clamped, never truncated garbage).
- frame_start_o:
  - Set on the enabled edge that loads position (0,0).
  - Cleared on the next clk_i edge regardless of en_i.
  - Never high for more than one clk cycle.
- With en_i=0, all outputs except frame_start_o hold, and the counters hold.
- No other state. Counters are free-running; there is no start or stop control.

## Timing
- Reset (rst_ni=0 at an edge):
  - Counters go to (0,0).
  - column_o=0, row_o=0, active_o=0, hsync_o=1, vsync_o=1, frame_start_o=0.
  - Reset takes priority over en_i.
- First enabled edge after reset release presents (0,0): active_o=1, frame_start_o=1. The counters then hold (1,0).
- All outputs are registered and mutually aligned: every output describes the same position. There is no combinational path from any input to any output.
- Latency: one enabled edge from counter value to output.
- Line period is 800 enabled ticks; frame period is 420 000 enabled ticks.
- Reset mid-frame behaves exactly like reset from power-up. There is no partial-line recovery.

## Structure
- Shared package vga_timing_pkg holds:
  - the eight timing constants above;
  - the derived H_TOTAL, V_TOTAL, H_SYNC_START/END and V_SYNC_START/END;
  - the COL_W=10 and ROW_W=9 width constants.
- The pattern generator also imports COL_W/ROW_W from vga_timing_pkg.
- Sub-module: mod_counter, a parameterized modulus-N counter with enable, synchronous active-low reset and a wrap (carry) output. It is instantiated twice: the horizontal instance's carry, ANDed with en_i, enables the vertical instance.

## Test plan
- Reset values: hold rst_ni=0 for 5 clks with en_i=1 -> all outputs at reset values. Release -> first edge gives column_o=0, row_o=0, active_o=1, frame_start_o=1 for exactly 1 clk.
- Hsync placement, en_i=1: hsync_o falls when column position 656 is presented and rises at 752 (96 ticks low). active_o falls after column 639; column_o reads 0 in blanking.
- Line/frame wrap:
  - (799, v) -> (0, v+1).
  - vsync_o low for exactly 1600 ticks, spanning lines 490-491.
  - (799, 524) -> (0, 0) with frame_start_o=1.
  - Consecutive frame_start_o pulses are 420 000 ticks apart.
- en_i stall: drive en_i 1-0-1-0 and hold it 0 for 10 clks mid-line -> outputs frozen and no position skipped. A frame_start_o that coincides with a stall still lasts only 1 clk.
- Reset mid-operation: assert rst_ni=0 at position (300, 200) for 1 clk -> reset values next cycle, then the sequence restarts at (0,0).
- Assertion checks: row_o < 480 and column_o < 640 whenever active_o=1; row_o = 0 and column_o = 0 whenever active_o=0.
